// File: rtl/pong_link_pkg.sv
// rtl/pong_link_pkg.sv - shared types, field layout and helpers for the pong inter-board link
package pong_link_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} link_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int PAYLOAD_BYTES = 6;
    localparam int PAYLOAD_W     = 8 * PAYLOAD_BYTES;

    // Field layout inside the 48-bit payload; the receive side unpacks with the same offsets.
    localparam int Y_PADDLE_W   = 10;
    localparam int X_BALL_W     = 11;
    localparam int Y_BALL_W     = 10;
    localparam int SCORE_W      = 4;
    localparam int STATE_W      = 2;
    localparam int Y_PADDLE_LSB = 38;
    localparam int X_BALL_LSB   = 27;
    localparam int Y_BALL_LSB   = 17;
    localparam int SCORE1_LSB   = 13;
    localparam int SCORE2_LSB   = 9;
    localparam int STATE_LSB    = 7;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [Y_PADDLE_W-1:0] y_paddle,
        input logic [X_BALL_W-1:0]   x_ball,
        input logic [Y_BALL_W-1:0]   y_ball,
        input logic [SCORE_W-1:0]    score1,
        input logic [SCORE_W-1:0]    score2,
        input logic [STATE_W-1:0]    game_state
    );
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        p[Y_PADDLE_LSB +: Y_PADDLE_W] = y_paddle;
        p[X_BALL_LSB   +: X_BALL_W]   = x_ball;
        p[Y_BALL_LSB   +: Y_BALL_W]   = y_ball;
        p[SCORE1_LSB   +: SCORE_W]    = score1;
        p[SCORE2_LSB   +: SCORE_W]    = score2;
        p[STATE_LSB    +: STATE_W]    = game_state;
        return p;
    endfunction

    // Byte 0 is the most significant payload byte.
    function automatic logic [7:0] payload_byte(
        input logic [PAYLOAD_W-1:0] p,
        input logic [2:0]           idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = p[47:40];
            3'd1:    b = p[39:32];
            3'd2:    b = p[31:24];
            3'd3:    b = p[23:16];
            3'd4:    b = p[15:8];
            3'd5:    b = p[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pong_link_tick_div.sv
// rtl/pong_link_tick_div.sv - frame tick divider with enable gating and drop detection
module pong_link_tick_div
    import pong_link_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_enable,
    input  logic i_frame_busy,
    output logic o_start,
    output logic o_dropped
);

    localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

    logic [7:0] r_div;
    logic       r_dropped;
    logic       w_sel;

    assign w_sel     = i_tick & i_enable & (r_div == LAST);
    assign o_start   = w_sel & ~i_frame_busy;
    assign o_dropped = r_dropped;

    // Divider only advances on enabled ticks, so it holds while the link is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= 8'd0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_sel & i_frame_busy;
            if (i_tick && i_enable) begin
                r_div <= (r_div == LAST) ? 8'd0 : r_div + 8'd1;
            end
        end
    end

endmodule

// File: rtl/pong_link_tx.sv
// rtl/pong_link_tx.sv - serialises a game-state snapshot into a framed byte stream
module pong_link_tx
    import pong_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        enable,
    input  logic [9:0]  y_player1,
    input  logic [10:0] x_ball,
    input  logic [9:0]  y_ball,
    input  logic [3:0]  player1_score,
    input  logic [3:0]  player2_score,
    input  logic [1:0]  state,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_dropped
);

    link_state_t          r_state, w_state_next;
    logic [2:0]           r_idx, w_idx_next;
    logic [7:0]           r_csum, w_csum_next;
    logic [PAYLOAD_W-1:0] r_payload, w_payload_next;
    logic [7:0]           r_tx_data, w_tx_data_next;
    logic                 r_tx_valid, w_tx_valid_next;
    logic                 r_busy, w_busy_next;
    logic                 w_start;
    logic                 w_xfer;
    logic [7:0]           w_csum_acc;

    pong_link_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (timing_tick),
        .i_enable     (enable),
        .i_frame_busy (r_busy),
        .o_start      (w_start),
        .o_dropped    (frame_dropped)
    );

    assign w_xfer   = r_tx_valid & tx_ready;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_csum     <= 8'd0;
            r_payload  <= '0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_csum     <= w_csum_next;
            r_payload  <= w_payload_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_valid <= w_tx_valid_next;
            r_busy     <= w_busy_next;
        end
    end

    // Every state holds its presented byte until the handshake, then loads the next one.
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_csum_next     = r_csum;
        w_payload_next  = r_payload;
        w_tx_data_next  = r_tx_data;
        w_tx_valid_next = r_tx_valid;
        w_busy_next     = r_busy;
        w_csum_acc      = r_csum ^ r_tx_data;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next    = SYNC;
                    w_payload_next  = pack_payload(y_player1, x_ball, y_ball,
                                                   player1_score, player2_score, state);
                    w_idx_next      = 3'd0;
                    w_tx_data_next  = SYNC_BYTE;
                    w_tx_valid_next = 1'b1;
                    w_busy_next     = 1'b1;
                end
            end
            SYNC: begin
                if (w_xfer) begin
                    w_state_next   = DATA;
                    w_idx_next     = 3'd0;
                    w_tx_data_next = payload_byte(r_payload, 3'd0);
                end
            end
            DATA: begin
                if (w_xfer) begin
                    w_csum_next = w_csum_acc;
                    if (r_idx == 3'(PAYLOAD_BYTES - 1)) begin
                        w_state_next   = CSUM;
                        w_tx_data_next = w_csum_acc;
                    end else begin
                        w_idx_next     = r_idx + 3'd1;
                        w_tx_data_next = payload_byte(r_payload, r_idx + 3'd1);
                    end
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    w_state_next    = IDLE;
                    w_csum_next     = 8'd0;
                    w_tx_data_next  = 8'd0;
                    w_tx_valid_next = 1'b0;
                    w_busy_next     = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pong_link_tx.sv
// tb/tb_pong_link_tx.sv - directed self-checking bench for pong_link_tx
module tb_pong_link_tx;

    typedef logic [7:0] frame_t [8];

    localparam frame_t GOLDEN = '{8'hA5, 8'h4B, 8'h10, 8'h03, 8'h00, 8'h6B, 8'h00, 8'h33};
    localparam frame_t ZEROS  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam frame_t ONES   = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h7F};

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic        timing_tick, enable, tx_ready;
    logic [9:0]  y_player1, y_ball;
    logic [10:0] x_ball;
    logic [3:0]  player1_score, player2_score;
    logic [1:0]  state;
    logic [7:0]  tx_data, tx_data3;
    logic        tx_valid, busy, frame_dropped;
    logic        tx_valid3, busy3, frame_dropped3;

    int          checks = 0;
    int          errors = 0;
    logic        ready_lvl = 1'b1;
    logic        rand_mode = 1'b0;
    logic        stall_chk = 1'b0;
    int          cyc = 0;
    int          drop_cnt = 0;
    int          tick_num = 0;
    logic [7:0]  rx_q[$];
    int          rx_cyc[$];
    int          rise_ticks[$];
    logic        p_stall = 1'b0;
    logic [7:0]  p_data = 8'h00;
    logic        p_valid3 = 1'b0;

    always #5 clk = ~clk;

    pong_link_tx #(.SYNC_BYTE(8'hA5), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .timing_tick(timing_tick), .enable(enable),
        .y_player1(y_player1), .x_ball(x_ball), .y_ball(y_ball),
        .player1_score(player1_score), .player2_score(player2_score), .state(state),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_dropped(frame_dropped)
    );

    pong_link_tx #(.SYNC_BYTE(8'hA5), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst(rst3), .timing_tick(timing_tick), .enable(enable),
        .y_player1(y_player1), .x_ball(x_ball), .y_ball(y_ball),
        .player1_score(player1_score), .player2_score(player2_score), .state(state),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(1'b1),
        .busy(busy3), .frame_dropped(frame_dropped3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        tx_ready = rand_mode ? ($urandom_range(0, 9) < 3) : ready_lvl;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            rx_cyc.push_back(cyc);
        end
        if (frame_dropped) drop_cnt++;
        if (stall_chk && p_stall) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(p_data));
        end
        p_stall = tx_valid && !tx_ready;
        p_data  = tx_data;
        if (tx_valid3 && !p_valid3) rise_ticks.push_back(tick_num);
        p_valid3 = tx_valid3;
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_tick();
        timing_tick = 1'b1;
        tick_num++;
        cycle();
        timing_tick = 1'b0;
    endtask

    task automatic set_in(input logic [9:0] y, input logic [10:0] x, input logic [9:0] yb,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [1:0] st);
        y_player1 = y; x_ball = x; y_ball = yb;
        player1_score = s1; player2_score = s2; state = st;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || tx_valid) && n < 400) begin
            cycle();
            n++;
        end
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_valid"}, 32'(tx_valid), 32'd0);
    endtask

    task automatic check_frame(input string tag, input frame_t exp);
        check({tag, "_len"}, 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'h1FF, 32'(exp[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; rst3 = 1'b1; timing_tick = 1'b0; enable = 1'b1;
        set_in(10'd0, 11'd0, 10'd0, 4'd0, 4'd0, 2'd0);
        repeat (3) cycle();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(frame_dropped), 32'd0);
        rst = 1'b0;
        repeat (2) cycle();

        // Golden frame, ready tied high
        set_in(10'd300, 11'd512, 10'd384, 4'd3, 4'd5, 2'd2);
        rx_q.delete(); rx_cyc.delete();
        do_tick();
        check("gold_lat_valid", 32'(tx_valid), 32'd1);
        check("gold_lat_data", 32'(tx_data), 32'hA5);
        check("gold_lat_busy", 32'(busy), 32'd1);
        wait_done("gold");
        check_frame("gold", GOLDEN);
        if (rx_cyc.size() == 8) check("gold_span", 32'(rx_cyc[7] - rx_cyc[0]), 32'd7);

        // Backpressure with inputs changed mid-frame
        repeat (2) cycle();
        rx_q.delete();
        stall_chk = 1'b1; rand_mode = 1'b1;
        do_tick();
        set_in(10'd1, 11'd2, 10'd3, 4'd4, 4'd6, 2'd1);
        wait_done("bp");
        rand_mode = 1'b0;
        cycle();
        stall_chk = 1'b0;
        check_frame("bp", GOLDEN);

        // Tick while busy is dropped
        set_in(10'd300, 11'd512, 10'd384, 4'd3, 4'd5, 2'd2);
        repeat (3) cycle();
        rx_q.delete(); drop_cnt = 0;
        do_tick();
        repeat (2) cycle();
        do_tick();
        wait_done("drop");
        repeat (5) cycle();
        check("drop_cnt", 32'(drop_cnt), 32'd1);
        check_frame("drop", GOLDEN);

        // Tick coincident with the checksum handshake
        rx_q.delete(); drop_cnt = 0;
        do_tick();
        n = 0;
        while (!(tx_valid && tx_data == 8'h33) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("csum_seen", 32'(n < 20), 32'd1);
        timing_tick = 1'b1;
        @(posedge clk);
        #2;
        timing_tick = 1'b0;
        check("coinc_valid", 32'(tx_valid), 32'd0);
        check("coinc_busy", 32'(busy), 32'd0);
        repeat (3) cycle();
        check("coinc_drop", 32'(drop_cnt), 32'd1);
        check("coinc_idle", 32'(tx_valid), 32'd0);
        check_frame("coinc", GOLDEN);

        // Divider by 3, then enable gating with the divider held
        rst3 = 1'b0;
        cycle();
        tick_num = 0; rise_ticks.delete();
        for (int i = 0; i < 7; i++) begin
            do_tick();
            repeat (11) cycle();
        end
        check("div_frames", 32'(rise_ticks.size()), 32'd2);
        if (rise_ticks.size() >= 2) begin
            check("div_first", 32'(rise_ticks[0]), 32'd3);
            check("div_second", 32'(rise_ticks[1]), 32'd6);
        end
        enable = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            do_tick();
            repeat (11) cycle();
        end
        check("dis_frames3", 32'(rise_ticks.size()), 32'd2);
        check("dis_frames1", 32'(rx_q.size()), 32'd0);
        enable = 1'b1;
        do_tick();
        repeat (11) cycle();
        check("hold_no_frame", 32'(rise_ticks.size()), 32'd2);
        do_tick();
        repeat (11) cycle();
        check("hold_frame", 32'(rise_ticks.size()), 32'd3);
        if (rise_ticks.size() >= 3) check("hold_tick", 32'(rise_ticks[2]), 32'd12);

        // Reset in the middle of a frame
        rx_q.delete();
        do_tick();
        n = 0;
        while (rx_q.size() < 4 && n < 20) begin
            cycle();
            n++;
        end
        check("mid_reached", 32'(n < 20), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        rx_q.delete();
        do_tick();
        wait_done("fresh");
        check_frame("fresh", GOLDEN);

        // Field extremes
        set_in(10'd0, 11'd0, 10'd0, 4'd0, 4'd0, 2'd0);
        rx_q.delete();
        do_tick();
        wait_done("zero");
        check_frame("zero", ZEROS);
        set_in(10'h3FF, 11'h7FF, 10'h3FF, 4'hF, 4'hF, 2'h3);
        rx_q.delete();
        do_tick();
        wait_done("ones");
        check_frame("ones", ONES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
